div_seq: RTL and testbench



---
 rtl/div_seq.sv | 159 +++++++++++++++
 tb/tb_div_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for the EX stage (DIV/DIVU).
// Produces one quotient bit per cycle and raises a combinational stall request
// while a division is pending or in flight.
// Ports:
//   clk, rst      clock (rising edge), synchronous active-high reset
//   signed_div_i  1 = signed DIV, 0 = unsigned DIVU
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       division request, held high until the result is consumed
//   annul_i       abort the division in progress
//   result_o      {remainder, quotient}, registered
//   ready_o       result_o valid, registered
//   stallreq_o    EX stall request, combinational
module div_seq #(
   parameter int unsigned DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o,
   output logic                  stallreq_o
);

   localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {S_IDLE, S_BY_ZERO, S_ON, S_END} state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic                sgn_mode, sgn_mode_n;
   logic                neg1, neg1_n;
   logic                neg2, neg2_n;
   logic [DATA_W-1:0]   dvd, dvd_n;        // dividend magnitude, shifts into quotient
   logic [DATA_W-1:0]   dvs, dvs_n;        // divisor magnitude
   logic [DATA_W-1:0]   rem, rem_n;        // partial remainder
   logic [2*DATA_W-1:0] result_n;
   logic                ready_n;

   // One restoring step: bring in next dividend bit, trial subtract on DATA_W+1 bits.
   logic [DATA_W:0]     shifted;
   logic [DATA_W:0]     diff;
   logic [DATA_W-1:0]   quot_fix;
   logic [DATA_W-1:0]   rem_fix;

   assign shifted  = {rem, dvd[DATA_W-1]};
   assign diff     = shifted - {1'b0, dvs};
   // Quotient negative when signs differ; remainder follows the dividend sign.
   assign quot_fix = (sgn_mode && (neg1 ^ neg2)) ? -dvd : dvd;
   assign rem_fix  = (sgn_mode && neg1) ? -rem : rem;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         sgn_mode <= 1'b0;
         neg1     <= 1'b0;
         neg2     <= 1'b0;
         dvd      <= '0;
         dvs      <= '0;
         rem      <= '0;
         result_o <= '0;
         ready_o  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         sgn_mode <= sgn_mode_n;
         neg1     <= neg1_n;
         neg2     <= neg2_n;
         dvd      <= dvd_n;
         dvs      <= dvs_n;
         rem      <= rem_n;
         result_o <= result_n;
         ready_o  <= ready_n;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      sgn_mode_n = sgn_mode;
      neg1_n     = neg1;
      neg2_n     = neg2;
      dvd_n      = dvd;
      dvs_n      = dvs;
      rem_n      = rem;
      result_n   = result_o;
      ready_n    = ready_o;
      case (state)
         S_IDLE: begin
            result_n = '0;
            ready_n  = 1'b0;
            if (start_i && !annul_i) begin
               sgn_mode_n = signed_div_i;
               neg1_n     = signed_div_i & opdata1_i[DATA_W-1];
               neg2_n     = signed_div_i & opdata2_i[DATA_W-1];
               dvd_n      = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
               dvs_n      = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
               rem_n      = '0;
               cnt_n      = '0;
               state_n    = (opdata2_i == '0) ? S_BY_ZERO : S_ON;
            end
         end
         S_BY_ZERO: begin
            state_n  = S_END;
            result_n = '0;
            ready_n  = 1'b1;
         end
         S_ON: begin
            if (annul_i) begin
               state_n  = S_IDLE;
               result_n = '0;
               ready_n  = 1'b0;
               cnt_n    = '0;
            end else if (cnt != CNT_W'(DATA_W)) begin
               // Borrow out of the trial subtract means restore (keep shifted value).
               if (diff[DATA_W]) begin
                  rem_n = shifted[DATA_W-1:0];
                  dvd_n = {dvd[DATA_W-2:0], 1'b0};
               end else begin
                  rem_n = diff[DATA_W-1:0];
                  dvd_n = {dvd[DATA_W-2:0], 1'b1};
               end
               cnt_n = cnt + CNT_W'(1);
            end else begin
               state_n  = S_END;
               result_n = {rem_fix, quot_fix};
               ready_n  = 1'b1;
               cnt_n    = '0;
            end
         end
         S_END: begin
            if (!start_i) begin
               state_n  = S_IDLE;
               result_n = '0;
               ready_n  = 1'b0;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Stall request: pending acceptance or division in flight.
   always_comb begin
      stallreq_o = 1'b0;
      case (state)
         S_IDLE:            stallreq_o = start_i & ~annul_i;
         S_BY_ZERO, S_ON:   stallreq_o = 1'b1;
         default:           stallreq_o = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq with a queue of expected results.
module tb_div_seq;

   localparam int unsigned DATA_W = 32;
   localparam int          DIV_EDGES  = DATA_W + 2;  // edges from driving start to ready
   localparam int          ZERO_EDGES = 2;

   logic                 clk;
   logic                 rst;
   logic                 signed_div_i;
   logic [DATA_W-1:0]    opdata1_i;
   logic [DATA_W-1:0]    opdata2_i;
   logic                 start_i;
   logic                 annul_i;
   logic [2*DATA_W-1:0]  result_o;
   logic                 ready_o;
   logic                 stallreq_o;

   int checks = 0;
   int errors = 0;
   logic [2*DATA_W-1:0] exp_q[$];

   div_seq #(.DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .stallreq_o   (stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: 64-bit arithmetic so the signed overflow case wraps naturally.
   function automatic logic [2*DATA_W-1:0] model(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic s);
      longint sa, sb, q, r;
      logic [DATA_W-1:0] uq, ur;
      if (b == '0) return '0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[DATA_W-1:0], q[DATA_W-1:0]};
      end
      uq = a / b;
      ur = a % b;
      return {ur, uq};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_start(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                              input logic s);
      opdata1_i    = a;
      opdata2_i    = b;
      signed_div_i = s;
      annul_i      = 1'b0;
      start_i      = 1'b1;
      #1;
      checks++;
      if (stallreq_o !== 1'b1) begin
         errors++;
         $display("FAIL pre_accept_stall got %0b want 1", stallreq_o);
      end
   endtask

   // Waits for ready, checks latency, stall count, END hold, annul ignore and release.
   task automatic wait_result(input int exp_edges);
      int n = 0;
      int stalls = 0;
      bit got = 0;
      logic [2*DATA_W-1:0] exp;
      while (n < 200 && !got) begin
         tick();
         n++;
         if (ready_o === 1'b1) got = 1;
         else if (stallreq_o === 1'b1) stalls++;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL ready_timeout got no ready after %0d edges want ready at %0d", n, exp_edges);
         start_i = 1'b0;
         tick();
         return;
      end
      checks++;
      if (n != exp_edges) begin
         errors++;
         $display("FAIL latency got %0d edges want %0d", n, exp_edges);
      end
      checks++;
      if (stalls != exp_edges - 1) begin
         errors++;
         $display("FAIL stall_cycles got %0d want %0d", stalls, exp_edges - 1);
      end
      checks++;
      if (stallreq_o !== 1'b0) begin
         errors++;
         $display("FAIL stall_in_end got %0b want 0", stallreq_o);
      end
      exp = '0;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty got result %h with no expectation", result_o);
      end else begin
         exp = exp_q.pop_front();
         if (result_o !== exp) begin
            errors++;
            $display("FAIL result got %h want %h", result_o, exp);
         end
      end
      // Held while start stays high; annul has no effect here.
      annul_i = 1'b1;
      tick();
      checks++;
      if (ready_o !== 1'b1 || result_o !== exp) begin
         errors++;
         $display("FAIL end_hold got ready %0b result %h want ready 1 result %h",
                  ready_o, result_o, exp);
      end
      annul_i = 1'b0;
      start_i = 1'b0;
      tick();
      checks++;
      if (ready_o !== 1'b0 || result_o !== '0 || stallreq_o !== 1'b0) begin
         errors++;
         $display("FAIL release got ready %0b result %h stall %0b want 0 0 0",
                  ready_o, result_o, stallreq_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start_i = 1'b0;
      annul_i = 1'b0;
      signed_div_i = 1'b0;
      opdata1_i = '0;
      opdata2_i = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++;
      if (ready_o !== 1'b0 || result_o !== '0 || stallreq_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got ready %0b result %h stall %0b want 0 0 0",
                  ready_o, result_o, stallreq_o);
      end
   endtask

   task automatic test_unsigned();
      drive_start(32'd100, 32'd7, 1'b0);
      exp_q.push_back(64'h00000002_0000000E);
      wait_result(DIV_EDGES);
      drive_start(32'hFFFFFFFF, 32'd1, 1'b0);
      exp_q.push_back(64'h00000000_FFFFFFFF);
      wait_result(DIV_EDGES);
      drive_start(32'd3, 32'hFFFFFFF0, 1'b0);
      exp_q.push_back(64'h00000003_00000000);
      wait_result(DIV_EDGES);
   endtask

   task automatic test_signed();
      drive_start(32'hFFFFFFF9, 32'd2, 1'b1);
      exp_q.push_back(64'hFFFFFFFF_FFFFFFFD);
      wait_result(DIV_EDGES);
      drive_start(32'd7, 32'hFFFFFFFE, 1'b1);
      exp_q.push_back(64'h00000001_FFFFFFFD);
      wait_result(DIV_EDGES);
      drive_start(32'h80000000, 32'hFFFFFFFF, 1'b1);
      exp_q.push_back(64'h00000000_80000000);
      wait_result(DIV_EDGES);
      drive_start(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1);
      exp_q.push_back(64'hFFFFFFFF_00000003);
      wait_result(DIV_EDGES);
   endtask

   task automatic test_by_zero();
      drive_start(32'd5, 32'd0, 1'b0);
      exp_q.push_back(64'h0);
      wait_result(ZERO_EDGES);
      drive_start(32'hFFFFFFFB, 32'd0, 1'b1);
      exp_q.push_back(64'h0);
      wait_result(ZERO_EDGES);
   endtask

   task automatic test_annul();
      drive_start(32'hFFFFFFFF, 32'd3, 1'b0);
      repeat (11) tick();      // acceptance edge plus ten iterations
      annul_i = 1'b1;
      tick();
      checks++;
      if (ready_o !== 1'b0 || result_o !== '0 || stallreq_o !== 1'b0) begin
         errors++;
         $display("FAIL annul_idle got ready %0b result %h stall %0b want 0 0 0",
                  ready_o, result_o, stallreq_o);
      end
      annul_i = 1'b0;
      #1;
      checks++;
      if (stallreq_o !== 1'b1) begin
         errors++;
         $display("FAIL annul_release_stall got %0b want 1", stallreq_o);
      end
      start_i = 1'b0;
      tick();
      drive_start(32'd9, 32'd3, 1'b0);
      exp_q.push_back(64'h00000000_00000003);
      wait_result(DIV_EDGES);
   endtask

   task automatic test_reset_mid();
      drive_start(32'd1000, 32'd13, 1'b0);
      repeat (21) tick();      // acceptance edge plus twenty iterations
      rst = 1'b1;
      tick();
      checks++;
      if (ready_o !== 1'b0 || result_o !== '0) begin
         errors++;
         $display("FAIL reset_mid got ready %0b result %h want 0 0", ready_o, result_o);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (stallreq_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_idle_stall got %0b want 1", stallreq_o);
      end
      exp_q.push_back(model(32'd1000, 32'd13, 1'b0));
      wait_result(DIV_EDGES);
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] a, b;
      logic s;
      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         b = (i % 3 == 0) ? DATA_W'($urandom_range(1, 15)) : DATA_W'($urandom);
         if (b == '0) b = 32'd1;
         s = i[0];
         drive_start(a, b, s);
         exp_q.push_back(model(a, b, s));
         wait_result(DIV_EDGES);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_by_zero();
      test_annul();
      test_reset_mid();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
